// File: rtl/rs_sched_pkg.sv
// Shared defaults and age arithmetic for the reservation-station scheduler.
package rs_sched_pkg;

    localparam int RS_DEPTH_DEF      = 8;
    localparam int MACHINE_WIDTH_DEF = 2;
    localparam int ISSUE_WIDTH_DEF   = 2;
    localparam int ROB_WIDTH_DEF     = 5;

    // Distance of a ROB tag from the head, modulo 2^age_w; smaller means older.
    function automatic logic [31:0] rel_age(input logic [31:0] age,
                                            input logic [31:0] head,
                                            input int          age_w);
        logic [31:0] mask;
        mask = (age_w >= 32) ? '1 : ((32'd1 << age_w) - 32'd1);
        return (age - head) & mask;
    endfunction

endpackage

// File: rtl/rs_sched_if.sv
// Status/control bundle between the reservation-station array and its scheduler.
interface rs_sched_if
    import rs_sched_pkg::*;
#(
    parameter int RS_DEPTH      = RS_DEPTH_DEF,
    parameter int MACHINE_WIDTH = MACHINE_WIDTH_DEF,
    parameter int ISSUE_WIDTH   = ISSUE_WIDTH_DEF,
    parameter int ROB_WIDTH     = ROB_WIDTH_DEF
);

    logic [RS_DEPTH-1:0]                      rs_avail;
    logic [RS_DEPTH-1:0]                      rs_issued;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]     rs_wake_up;
    logic [RS_DEPTH-1:0][ROB_WIDTH:0]         rs_age;
    logic [RS_DEPTH-1:0][MACHINE_WIDTH-1:0]   alloc_sel;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]     issue_sel;
    logic [ISSUE_WIDTH-1:0]                   issue_valid;
    logic [RS_DEPTH-1:0]                      rs_use_en;

    modport master (
        input  rs_avail, rs_issued, rs_wake_up, rs_age,
        output alloc_sel, issue_sel, issue_valid, rs_use_en
    );

    modport slave (
        output rs_avail, rs_issued, rs_wake_up, rs_age,
        input  alloc_sel, issue_sel, issue_valid, rs_use_en
    );

endinterface

// File: rtl/rs_age_picker.sv
// One-hot picker for a single issue port: oldest request when RS_SCHED_AGE_EN is
// defined, otherwise the lowest-index request (ages ignored, no comparators).
module rs_age_picker
    import rs_sched_pkg::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic [RS_DEPTH-1:0]              req,
    input  logic [RS_DEPTH-1:0][ROB_WIDTH:0] age,
    input  logic [ROB_WIDTH:0]               head,
    output logic [RS_DEPTH-1:0]              grant
);

`ifdef RS_SCHED_AGE_EN
    logic [ROB_WIDTH:0] best_age;
    logic [ROB_WIDTH:0] cur_age;
    logic               found;

    // Strict less-than keeps the earlier (lower-index) entry on a tie.
    always_comb begin
        grant    = '0;
        best_age = '0;
        cur_age  = '0;
        found    = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (req[i]) begin
                cur_age = (ROB_WIDTH+1)'(rel_age(32'(age[i]), 32'(head), ROB_WIDTH + 1));
                if (!found || cur_age < best_age) begin
                    found    = 1'b1;
                    best_age = cur_age;
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end
`else
    logic unused_age;

    assign grant      = req & (~req + 1'b1);
    assign unused_age = ^{age, head};
`endif

endmodule

// File: rtl/rs_sched.sv
// Reservation-station scheduler: round-robin allocation and per-port issue select
// with a one-cycle grant register. RS_SCHED_AGE_EN selects oldest-first issue.
module rs_sched
    import rs_sched_pkg::*;
#(
    parameter int RS_DEPTH      = RS_DEPTH_DEF,
    parameter int MACHINE_WIDTH = MACHINE_WIDTH_DEF,
    parameter int ISSUE_WIDTH   = ISSUE_WIDTH_DEF,
    parameter int ROB_WIDTH     = ROB_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_flush,
    input  logic [MACHINE_WIDTH-1:0] dispatch_valid,
    input  logic [ROB_WIDTH:0]       rob_head,
    input  logic [ISSUE_WIDTH-1:0]   fu_ready,
    output logic                     dispatch_stall,
    rs_sched_if.master               bus
);

    localparam int PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [PTR_W-1:0]                        alloc_ptr;
    logic [PTR_W-1:0]                        alloc_ptr_nxt;
    logic [RS_DEPTH-1:0]                     alloc_mask;
    logic [RS_DEPTH-1:0][MACHINE_WIDTH-1:0]  alloc_sel_c;
    logic                                    stall_nxt;
    logic [PTR_W:0]                          scan_sum;
    logic [PTR_W-1:0]                        scan_idx;
    int                                      nfree;
    int                                      slot_rank;

    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    cand;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    excl;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    req;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    grant;
    logic [ISSUE_WIDTH-1:0]                  grant_vld;
    logic [RS_DEPTH-1:0]                     grant_any;

    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    issue_sel_p1;
    logic [ISSUE_WIDTH-1:0]                  vld_p1;
    logic [RS_DEPTH-1:0]                     pend_mask;

    // Stage 0: allocation. The n-th free entry in scan order pairs with the n-th valid slot.
    always_comb begin
        alloc_sel_c   = '0;
        alloc_mask    = '0;
        alloc_ptr_nxt = alloc_ptr;
        scan_sum      = '0;
        scan_idx      = '0;
        nfree         = 0;
        slot_rank     = 0;
        if (!dispatch_stall) begin
            for (int off = 0; off < RS_DEPTH; off++) begin
                scan_sum = {1'b0, alloc_ptr} + (PTR_W+1)'(off);
                if (scan_sum >= (PTR_W+1)'(RS_DEPTH))
                    scan_sum = scan_sum - (PTR_W+1)'(RS_DEPTH);
                scan_idx = scan_sum[PTR_W-1:0];
                if (bus.rs_avail[scan_idx]) begin
                    slot_rank = 0;
                    for (int k = 0; k < MACHINE_WIDTH; k++) begin
                        if (dispatch_valid[k]) begin
                            if (slot_rank == nfree) begin
                                alloc_sel_c[scan_idx][k] = 1'b1;
                                alloc_mask[scan_idx]     = 1'b1;
                                alloc_ptr_nxt = (scan_idx == PTR_W'(RS_DEPTH - 1)) ?
                                                '0 : scan_idx + 1'b1;
                            end
                            slot_rank++;
                        end
                    end
                    nfree++;
                end
            end
        end
    end

    // Conservative: a full group must still fit in whatever stays free after this cycle.
    assign stall_nxt     = ($countones(bus.rs_avail & ~alloc_mask) < MACHINE_WIDTH);
    assign bus.alloc_sel = alloc_sel_c;

    // Stage 0: issue select, port 0 first; later ports skip earlier winners.
    for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_port
        if (p == 0) begin : g_first
            assign excl[p] = '0;
        end else begin : g_rest
            assign excl[p] = excl[p-1] | grant[p-1];
        end

        assign cand[p] = bus.rs_wake_up[p] & ~bus.rs_issued & ~bus.rs_avail & ~pend_mask;
        assign req[p]  = fu_ready[p] ? (cand[p] & ~excl[p]) : '0;

        rs_age_picker #(
            .RS_DEPTH  (RS_DEPTH),
            .ROB_WIDTH (ROB_WIDTH)
        ) u_picker (
            .req   (req[p]),
            .age   (bus.rs_age),
            .head  (rob_head),
            .grant (grant[p])
        );

        assign grant_vld[p] = |grant[p];
    end

    always_comb begin
        grant_any = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++)
            grant_any |= grant[p];
    end

    // Stage 1: registered grants. pend_mask doubles as rs_use_en and hides the
    // granted entries until the array reports them issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr      <= '0;
            dispatch_stall <= 1'b0;
            issue_sel_p1   <= '0;
            vld_p1         <= '0;
            pend_mask      <= '0;
        end else if (pipe_flush) begin
            alloc_ptr      <= '0;
            dispatch_stall <= 1'b0;
            issue_sel_p1   <= '0;
            vld_p1         <= '0;
            pend_mask      <= '0;
        end else begin
            alloc_ptr      <= alloc_ptr_nxt;
            dispatch_stall <= stall_nxt;
            issue_sel_p1   <= grant;
            vld_p1         <= grant_vld;
            pend_mask      <= grant_any;
        end
    end

    assign bus.issue_sel   = issue_sel_p1;
    assign bus.issue_valid = vld_p1;
    assign bus.rs_use_en   = pend_mask;

endmodule
